// File: rtl/riscy_mem_pkg.sv
// rtl/riscy_mem_pkg.sv - shared types, defaults and address checking for the data memory responder
package riscy_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned DEPTH_WORDS_DEF = 256;
    localparam int unsigned WAIT_CYCLES_DEF = 2;

    // An access is rejected when it is not word aligned or lies beyond the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/sram_be_word.sv
// rtl/sram_be_word.sv - single-port word array with byte enables and registered read
module sram_be_word #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write and read-before-write registered read; contents have no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - request/response memory slave with fixed wait-state latency
module data_mem_responder
    import riscy_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        write_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic        rd_sel_q;

    logic        accept;
    logic        enter_resp;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_write;
    logic        acc_err;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // The array sees the live request while idle (zero-wait case) and the latched one afterwards.
    always_comb begin
        accept     = req_valid && req_ready_q;
        acc_addr   = (state_q == IDLE) ? req_addr  : addr_q;
        acc_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
        acc_be     = (state_q == IDLE) ? req_be    : be_q;
        acc_write  = (state_q == IDLE) ? req_write : write_q;
        acc_err    = addr_err(acc_addr, DEPTH_WORDS);
        enter_resp = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd0));
        mem_we     = enter_resp && acc_write && !acc_err;
    end

    sram_be_word #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .be    (acc_be),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // Transaction FSM: accept, count wait states, then hold the response until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            write_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        write_q     <= req_write;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= acc_err;
                            rd_sel_q    <= !req_write && !acc_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rd_sel_q    <= !write_q && !acc_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_sel_q    <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rd_sel_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rd_sel_q ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for the data memory responder
module tb_data_mem_responder;

    localparam int WC = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_write0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_be0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t        exp_q[$];
    logic [31:0] model [int unsigned];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_write (req_write0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .req_be    (req_be0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
        exp_t        e;
        int unsigned idx;
        logic [31:0] word;
        e.err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
        idx   = addr >> 2;
        word  = model.exists(idx) ? model[idx] : 32'd0;
        e.rdata = (w || e.err) ? 32'd0 : word;
        if (w && !e.err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
            model[idx] = word;
        end
        exp_q.push_back(e);
    endtask

    task automatic txn(input string tag, input logic w, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, req_ready, 1'b1);
        push_exp(w, addr, wdata, be);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_lat"}, n, WC + 1);
        e = exp_q.pop_front();
        if (hold > 0) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
            req_wdata = 32'h2222_2222; req_be = 4'hF;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, rsp_valid, 1'b1);
                chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
                chk({tag, "_hold_err"}, rsp_err, e.err);
                chk({tag, "_hold_ready"}, req_ready, 1'b0);
            end
            req_valid = 1'b0;
        end
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, rsp_err, e.err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, rsp_valid, 1'b0);
        chk({tag, "_idle"}, req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_cnt, acc_cnt, err_cnt;
        logic first_rv;
        rst = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
        req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; rsp_ready0 = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        txn("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        txn("rd10", 1'b0, 32'h10, 32'h0, 4'hF, 0);
        txn("wr10_be", 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 0);
        txn("rd10_be", 1'b0, 32'h10, 32'h0, 4'hF, 0);
        txn("wr00", 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 0);
        txn("rd13_mis", 1'b0, 32'h13, 32'h0, 4'hF, 0);
        txn("wr400_oor", 1'b1, 32'h400, 32'h5555_5555, 4'hF, 0);
        txn("rd00", 1'b0, 32'h0, 32'h0, 4'hF, 0);
        txn("wr10_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0);
        txn("rd10_be0", 1'b0, 32'h10, 32'h0, 4'hF, 0);
        txn("wr3fc", 1'b1, 32'h3FC, 32'h0BAD_F00D, 4'hF, 0);
        txn("rd3fc", 1'b0, 32'h3FC, 32'h0, 4'hF, 0);
        txn("rd3fd_mis", 1'b0, 32'h3FD, 32'h0, 4'hF, 0);
        txn("wr30", 1'b1, 32'h30, 32'h1111_1111, 4'hF, 0);
        txn("rd30_hold", 1'b0, 32'h30, 32'h0, 4'hF, 5);
        txn("rd30_after", 1'b0, 32'h30, 32'h0, 4'hF, 0);

        // Reset while a write to 0x20 sits in WAIT; the older contents must survive.
        txn("wr20", 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midwait_ready", req_ready, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async_req_ready", req_ready, 1'b1);
        chk("async_rsp_valid", rsp_valid, 1'b0);
        chk("async_rsp_err", rsp_err, 1'b0);
        chk("async_rsp_rdata", rsp_rdata, 32'd0);
        repeat (3) @(negedge clk);
        chk("held_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        txn("rd20_after_rst", 1'b0, 32'h20, 32'h0, 4'hF, 0);

        // Zero-wait instance: continuous reads with the response always taken.
        @(negedge clk);
        req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h4; req_be0 = 4'hF; rsp_ready0 = 1'b1;
        rv_cnt = 0; acc_cnt = 0; err_cnt = 0;
        @(negedge clk);
        first_rv = rsp_valid0;
        if (rsp_valid0) rv_cnt++;
        if (req_ready0) acc_cnt++;
        if (rsp_err0) err_cnt++;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid0) rv_cnt++;
            if (req_ready0) acc_cnt++;
            if (rsp_err0) err_cnt++;
        end
        req_valid0 = 1'b0;
        chk("w0_first_rsp", first_rv, 1'b1);
        chk("w0_rsp_count", rv_cnt, 10);
        chk("w0_ready_count", acc_cnt, 10);
        chk("w0_err_count", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
